// File: rtl/alarm_pkg.sv
// Shared types for the alarm tone generator: cadence FSM states and cadence modes.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } cad_state_t;

   localparam logic [1:0] MODE_CONT   = 2'd0;
   localparam logic [1:0] MODE_BEEP   = 2'd1;
   localparam logic [1:0] MODE_TRIPLE = 2'd2;

endpackage

// File: rtl/alarm_tone_core.sv
// Square-wave tone generator with a shadowed half-period, reloaded only at
// half-period boundaries so divider writes never produce runt pulses.
module alarm_tone_core (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] div_value,
   input  logic        run,
   input  logic        start,
   output logic        tone_out
);

   logic [31:0] shadow;
   logic [31:0] tone_cnt;
   logic        div_ok;

   assign div_ok = (div_value > 32'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow   <= 32'd0;
         tone_cnt <= 32'd0;
         tone_out <= 1'b0;
      end else if (start) begin
         shadow   <= div_value;
         tone_cnt <= 32'd0;
         tone_out <= div_ok;
      end else if (run) begin
         // A degenerate shadow keeps reloading so a valid divider starts the tone at once.
         if (shadow < 32'd2) begin
            shadow   <= div_value;
            tone_cnt <= 32'd0;
            tone_out <= div_ok;
         end else if (tone_cnt == shadow - 32'd1) begin
            shadow   <= div_value;
            tone_cnt <= 32'd0;
            tone_out <= div_ok & ~tone_out;
         end else begin
            tone_cnt <= tone_cnt + 32'd1;
         end
      end else begin
         shadow   <= 32'd0;
         tone_cnt <= 32'd0;
         tone_out <= 1'b0;
      end
   end

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm buzzer driver: cadence FSM (continuous / beep-repeat / triple-beep)
// gating a divider-programmed square-wave tone.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | alarm off, buzzer silent
//   ST_ON   | tone burst (or continuous tone in mode 0/3)
//   ST_OFF  | silence between beeps
//   ST_GAP  | silence after the third beep of a triple group
module alarm_tone_gen
   import alarm_pkg::*;
#(
   parameter int unsigned BEEP_ON  = 25_000_000,
   parameter int unsigned BEEP_OFF = 25_000_000,
   parameter int unsigned GAP      = 50_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] div_value,
   input  logic        alarm_en,
   input  logic [1:0]  mode,
   output logic        buzzer_out,
   output logic        active,
   output logic        cycle_done
);

   localparam logic [31:0] ON_LAST  = 32'(BEEP_ON - 1);
   localparam logic [31:0] OFF_LAST = 32'(BEEP_OFF - 1);
   localparam logic [31:0] GAP_LAST = 32'(GAP - 1);

   cad_state_t  state, state_nxt;
   logic [31:0] cad_cnt, cad_cnt_nxt;
   logic [1:0]  beep_cnt, beep_cnt_nxt;
   logic [1:0]  mode_lat, mode_lat_nxt;
   logic        run, start, active_nxt, cycle_done_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cad_cnt    <= 32'd0;
         beep_cnt   <= 2'd0;
         mode_lat   <= MODE_CONT;
         active     <= 1'b0;
         cycle_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cad_cnt    <= cad_cnt_nxt;
         beep_cnt   <= beep_cnt_nxt;
         mode_lat   <= mode_lat_nxt;
         active     <= active_nxt;
         cycle_done <= cycle_done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cad_cnt_nxt  = cad_cnt + 32'd1;
      beep_cnt_nxt = beep_cnt;
      mode_lat_nxt = mode_lat;
      if (!alarm_en) begin
         state_nxt    = ST_IDLE;
         cad_cnt_nxt  = 32'd0;
         beep_cnt_nxt = 2'd0;
         mode_lat_nxt = MODE_CONT;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt    = ST_ON;
               cad_cnt_nxt  = 32'd0;
               beep_cnt_nxt = 2'd0;
               mode_lat_nxt = mode;
            end
            ST_ON: begin
               case (mode_lat)
                  MODE_BEEP: begin
                     if (cad_cnt == ON_LAST) begin
                        state_nxt   = ST_OFF;
                        cad_cnt_nxt = 32'd0;
                     end
                  end
                  MODE_TRIPLE: begin
                     if (cad_cnt == ON_LAST) begin
                        state_nxt   = (beep_cnt == 2'd2) ? ST_GAP : ST_OFF;
                        cad_cnt_nxt = 32'd0;
                     end
                  end
                  // continuous tone: counter parked so it can never wrap
                  default: cad_cnt_nxt = 32'd0;
               endcase
            end
            ST_OFF: begin
               if (cad_cnt == OFF_LAST) begin
                  state_nxt    = ST_ON;
                  cad_cnt_nxt  = 32'd0;
                  beep_cnt_nxt = (mode_lat == MODE_TRIPLE) ? beep_cnt + 2'd1 : 2'd0;
               end
            end
            ST_GAP: begin
               if (cad_cnt == GAP_LAST) begin
                  state_nxt    = ST_ON;
                  cad_cnt_nxt  = 32'd0;
                  beep_cnt_nxt = 2'd0;
               end
            end
            default: begin
               state_nxt   = ST_IDLE;
               cad_cnt_nxt = 32'd0;
            end
         endcase
      end
   end

   always_comb begin
      run            = (state_nxt == ST_ON);
      start          = run && (state != ST_ON);
      active_nxt     = (state_nxt != ST_IDLE);
      cycle_done_nxt = (state_nxt == ST_GAP) && (cad_cnt_nxt == GAP_LAST);
   end

   alarm_tone_core u_tone (
      .clk       (clk),
      .reset_n   (reset_n),
      .div_value (div_value),
      .run       (run),
      .start     (start),
      .tone_out  (buzzer_out)
   );

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Scoreboarded bench for alarm_tone_gen with short cadence parameters.
module tb_alarm_tone_gen;

   localparam int unsigned BEEP_ON  = 20;
   localparam int unsigned BEEP_OFF = 10;
   localparam int unsigned GAP      = 40;

   logic        clk;
   logic        reset_n;
   logic [31:0] div_value;
   logic        alarm_en;
   logic [1:0]  mode;
   logic        buzzer_out;
   logic        active;
   logic        cycle_done;

   typedef struct packed {
      logic buz;
      logic act;
      logic cd;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   alarm_tone_gen #(
      .BEEP_ON  (BEEP_ON),
      .BEEP_OFF (BEEP_OFF),
      .GAP      (GAP)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .div_value  (div_value),
      .alarm_en   (alarm_en),
      .mode       (mode),
      .buzzer_out (buzzer_out),
      .active     (active),
      .cycle_done (cycle_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp_v);
      end
   endtask

   // Expected outputs for the next clock edge; inputs must already be set.
   task automatic cyc(input logic b, input logic a, input logic c);
      exp_t e;
      e.buz = b;
      e.act = a;
      e.cd  = c;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("buzzer_out", {31'd0, buzzer_out}, {31'd0, e.buz});
         chk("active",     {31'd0, active},     {31'd0, e.act});
         chk("cycle_done", {31'd0, cycle_done}, {31'd0, e.cd});
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      alarm_en  = 1'b1;
      div_value = 32'd4;
      mode      = 2'd0;
      #1;
      chk("rst_buzzer", {31'd0, buzzer_out}, 32'd0);
      chk("rst_active", {31'd0, active},     32'd0);
      chk("rst_cdone",  {31'd0, cycle_done}, 32'd0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      reset_n  = 1'b1;
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // continuous, div 4: 4 high / 4 low; drop while high
      mode = 2'd0; div_value = 32'd4; alarm_en = 1'b1;
      for (int k = 0; k < 204; k++) cyc(((k / 4) % 2) == 0, 1'b1, 1'b0);
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // beep-repeat, div 2: 20 toggling, 10 silent; mode change mid-run ignored
      mode = 2'd1; div_value = 32'd2; alarm_en = 1'b1;
      for (int k = 0; k < 90; k++) begin
         if (k == 45) mode = 2'd0;
         cyc(((k % 30) < 20) && ((((k % 30) / 2) % 2) == 0), 1'b1, 1'b0);
      end
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      alarm_en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k == 20) mode = 2'd2;
         cyc(((k / 2) % 2) == 0, 1'b1, 1'b0);
      end
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // triple-beep, div 3: 20 on,10 off,20 on,10 off,20 on,40 gap
      mode = 2'd2; div_value = 32'd3; alarm_en = 1'b1;
      for (int k = 0; k < 240; k++) begin
         int p, t;
         logic on;
         p  = k % 120;
         on = 1'b1;
         if (p < 20) t = p;
         else if (p >= 30 && p < 50) t = p - 30;
         else if (p >= 60 && p < 80) t = p - 60;
         else begin
            t  = 0;
            on = 1'b0;
         end
         cyc(on && (((t / 3) % 2) == 0), 1'b1, p == 119);
      end
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // mode 3 behaves continuous; divider changes land on half-period boundaries
      mode = 2'd3; div_value = 32'd4; alarm_en = 1'b1;
      for (int k = 0; k < 84; k++) begin
         logic b;
         if (k == 10) div_value = 32'd6;
         if (k == 48) div_value = 32'd1;
         if (k == 68) div_value = 32'd4;
         if (k < 12)      b = ((k / 4) % 2) == 0;
         else if (k < 48) b = (((k - 12) / 6) % 2) == 1;
         else if (k < 68) b = 1'b0;
         else             b = (((k - 68) / 4) % 2) == 0;
         cyc(b, 1'b1, 1'b0);
      end
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // asynchronous reset mid-beep
      mode = 2'd1; div_value = 32'd2; alarm_en = 1'b1;
      for (int k = 0; k < 6; k++) cyc(((k / 2) % 2) == 0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("pre_rst_buzzer", {31'd0, buzzer_out}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_buzzer", {31'd0, buzzer_out}, 32'd0);
      chk("async_rst_active", {31'd0, active},     32'd0);
      chk("async_rst_cdone",  {31'd0, cycle_done}, 32'd0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int k = 0; k < 16; k++) cyc(((k / 2) % 2) == 0, 1'b1, 1'b0);
      alarm_en = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
